matmul_4x4: RTL and testbench

//   Clocked 4x4 signed integer matrix multiplier, C = A x B, on an output-stationary systolic array.
//   - 16 MAC processing elements, one per C[i][j].
//   - A rows enter from the left, skewed by i cycles; B columns enter from the top, skewed by j cycles.
//   - Leaf arithmetic block for matrix/NN datapaths; operands and results are unpacked 2-D arrays.

---
 rtl/matmul_4x4_if.sv | 17 +
 rtl/matmul_4x4.sv | 99 +++++++++
 tb/tb_matmul_4x4.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/matmul_4x4_if.sv
// matmul_4x4_if: operand/result bundle for matmul_4x4.
// Signals: start (request), a/b (signed operand matrices), c (registered result),
// busy (operation in flight), done (one-cycle result-valid pulse).
// master = requester side, slave = multiplier side.
interface matmul_4x4_if #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 16
);
   logic start;
   logic busy;
   logic done;
   logic signed [DATA_W-1:0] a [0:3][0:3];
   logic signed [DATA_W-1:0] b [0:3][0:3];
   logic signed [OUT_W-1:0]  c [0:3][0:3];
   modport master (output start, a, b, input c, busy, done);
   modport slave (input start, a, b, output c, busy, done);
endinterface

// File: rtl/matmul_4x4.sv
// matmul_4x4: 4x4 signed matrix multiply C = A x B on an output-stationary systolic array.
// Ports: clk, reset (sync, active-high), bus (matmul_4x4_if.slave: start, a, b in; c, busy, done out).
// Build option MATMUL_SATURATE_EN: clamp results to the OUT_W range instead of wrapping.
module matmul_4x4 #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 16
) (
   input logic          clk,
   input logic          reset,
   matmul_4x4_if.slave  bus
);
   localparam int ACC_W = 2 * DATA_W + 2;
   localparam int PW    = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2 ** (OUT_W - 1)));
`ifdef MATMUL_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;
   state_t state, state_n;
   logic [3:0] cnt, d;
   logic go;
   logic signed [DATA_W-1:0] op_a [0:3][0:3];
   logic signed [DATA_W-1:0] op_b [0:3][0:3];
   logic signed [DATA_W-1:0] ha [0:3][0:2];
   logic signed [DATA_W-1:0] vb [0:2][0:3];
   logic signed [DATA_W-1:0] fa [0:3];
   logic signed [DATA_W-1:0] fb [0:3];
   logic signed [DATA_W-1:0] ain [0:3][0:3];
   logic signed [DATA_W-1:0] bin [0:3][0:3];
   logic signed [PW-1:0]     prod [0:3][0:3];
   logic signed [ACC_W-1:0]  acc [0:3][0:3];
   logic signed [OUT_W-1:0]  res [0:3][0:3];
   assign go       = bus.start && state == IDLE;
   assign bus.busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = go ? COMPUTE : (state == COMPUTE && cnt == 4'd10) ? FINISH : state == FINISH ? IDLE : state;
   end
   // Edge feeds: row i / column j see element t-i / t-j, zero outside the 4-wide window (skew).
   always_comb begin
      d = '0;
      for (int i = 0; i < 4; i++) begin
         d = cnt - 4'(i);
         fa[i] = (cnt >= 4'(i) && d < 4'd4) ? op_a[i][d[1:0]] : '0;
         fb[i] = (cnt >= 4'(i) && d < 4'd4) ? op_b[d[1:0]][i] : '0;
      end
      for (int i = 0; i < 4; i++) begin
         ain[i][0] = fa[i];
         bin[0][i] = fb[i];
         for (int j = 1; j < 4; j++) begin
            ain[i][j] = ha[i][j-1];
            bin[j][i] = vb[j-1][i];
         end
      end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            prod[i][j] = PW'(ain[i][j]) * PW'(bin[i][j]);
            res[i][j]  = (SAT && acc[i][j] > MAXV) ? MAXV[OUT_W-1:0] :
                         (SAT && acc[i][j] < MINV) ? MINV[OUT_W-1:0] : acc[i][j][OUT_W-1:0];
         end
   end
   // cnt runs 0..10; the last step only flushes zeros, giving the 12-cycle start-to-done latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         bus.done <= 1'b0;
         op_a     <= '{default: '0};
         op_b     <= '{default: '0};
         ha       <= '{default: '0};
         vb       <= '{default: '0};
         acc      <= '{default: '0};
         bus.c    <= '{default: '0};
      end else begin
         cnt      <= state == COMPUTE ? cnt + 4'd1 : '0;
         bus.done <= state == FINISH;
         if (go) begin
            op_a <= bus.a;
            op_b <= bus.b;
            ha   <= '{default: '0};
            vb   <= '{default: '0};
            acc  <= '{default: '0};
         end else if (state == COMPUTE) begin
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++) begin
                  acc[i][j] <= acc[i][j] + ACC_W'(prod[i][j]);
                  if (j < 3) ha[i][j] <= ain[i][j];
                  if (i < 3) vb[i][j] <= bin[i][j];
               end
         end
         if (state == FINISH) bus.c <= res;
      end
   end
endmodule

// File: tb/tb_matmul_4x4.sv
// tb_matmul_4x4: self-checking bench for matmul_4x4 (directed table, random vectors, timing corner cases).
module tb_matmul_4x4;
   typedef struct {
      int a [4][4];
      int b [4][4];
      int e [4][4];
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tot = 0;
   int bad = 0;
   vec_t tv [$];
   matmul_4x4_if #(.DATA_W(8), .OUT_W(16)) bus ();
   matmul_4x4 #(.DATA_W(8), .OUT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   function automatic int conv(int s);
`ifdef MATMUL_SATURATE_EN
      return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
`else
      return int'($signed(16'(s)));
`endif
   endfunction
   function automatic vec_t with_exp(vec_t v);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            int s = 0;
            for (int k = 0; k < 4; k++) s += v.a[i][k] * v.b[k][j];
            v.e[i][j] = conv(s);
         end
      return v;
   endfunction
   task automatic check(input string nm, input int got, input int exp);
      tot++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask
   task automatic check_c(input string nm, input int e [4][4]);
      int nb = 0;
      string s = "";
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (int'(bus.c[i][j]) != e[i][j]) begin
               if (nb == 0) s = $sformatf("c[%0d][%0d] got %0d expected %0d", i, j, int'(bus.c[i][j]), e[i][j]);
               nb++;
            end
      tot++;
      if (nb != 0) begin
         bad++;
         $display("FAIL %s: %0d elements differ, first %s", nm, nb, s);
      end
   endtask
   task automatic start_op(input vec_t v);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            bus.a[i][j] = 8'(v.a[i][j]);
            bus.b[i][j] = 8'(v.b[i][j]);
         end
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            bus.a[i][j] = 8'($urandom);
            bus.b[i][j] = 8'($urandom);
         end
   endtask
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.done && lat < 40);
   endtask
   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bus.done) cnt++;
      end
   endtask
   initial begin
      vec_t v, v2;
      int lat, nd;
      int z [4][4];
      int b2 [4][4];
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            bus.a[i][j] = '0;
            bus.b[i][j] = '0;
            z[i][j] = 0;
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            v.a[i][j] = (i == j) ? 1 : 0;
            v.b[i][j] = 4 * i + j + 1;
            v.e[i][j] = 4 * i + j + 1;
            b2[i][j] = 2 * (4 * i + j + 1);
         end
      tv.push_back(v);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            v.a[i][j] = -1;
            v.b[i][j] = (i == j) ? 3 : 0;
            v.e[i][j] = -3;
         end
      tv.push_back(v);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            v.a[i][j] = 2;
            v.b[i][j] = 2;
            v.e[i][j] = 16;
         end
      tv.push_back(v);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            v.a[i][j] = -128;
            v.b[i][j] = -128;
`ifdef MATMUL_SATURATE_EN
            v.e[i][j] = 32767;
`else
            v.e[i][j] = 0;
`endif
         end
      tv.push_back(v);
      repeat (8) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
               v.a[i][j] = int'($urandom_range(255)) - 128;
               v.b[i][j] = int'($urandom_range(255)) - 128;
            end
         tv.push_back(with_exp(v));
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check_c("reset c", z);
      reset = 1'b0;
      @(posedge clk);
      #1;
      foreach (tv[n]) begin
         start_op(tv[n]);
         check($sformatf("vec%0d busy", n), int'(bus.busy), 1);
         wait_done(lat);
         check($sformatf("vec%0d latency", n), lat, 12);
         check($sformatf("vec%0d busy in done", n), int'(bus.busy), 0);
         check_c($sformatf("vec%0d c", n), tv[n].e);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d done pulse width", n), int'(bus.done), 0);
         check_c($sformatf("vec%0d c hold", n), tv[n].e);
      end
      start_op(tv[0]);
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            bus.a[i][j] = 8'(tv[5].a[i][j]);
            bus.b[i][j] = 8'(tv[5].b[i][j]);
         end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat);
      check("busy-start latency", lat, 7);
      check_c("busy-start c", tv[0].e);
      count_done(20, nd);
      check("busy-start extra done", nd, 0);
      start_op(tv[0]);
      wait_done(lat);
      check_c("b2b first c", tv[0].e);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) v2.a[i][j] = (i == j) ? 2 : 0;
      v2.b = tv[0].b;
      start_op(v2);
      repeat (5) @(posedge clk);
      #1;
      check_c("b2b c stable mid-op", tv[0].e);
      wait_done(lat);
      check("b2b latency", lat + 5, 12);
      check_c("b2b second c", b2);
      start_op(tv[6]);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_c("mid reset c", z);
      check("mid reset busy", int'(bus.busy), 0);
      count_done(20, nd);
      check("mid reset no done", nd, 0);
      start_op(tv[7]);
      wait_done(lat);
      check("after reset latency", lat, 12);
      check_c("after reset c", tv[7].e);
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule
